// File: rtl/hf_tans_pkg.sv
// rtl/hf_tans_pkg.sv - shared widths and types for the tANS bit packer
package hf_tans_pkg;

  localparam int IN_W    = 3;
  localparam int STATE_W = 4;
  localparam int OUT_W   = 8;

  typedef enum logic [1:0] {
    S_RUN,
    S_APPEND,
    S_PAD
  } pack_state_t;

  typedef logic [1:0] nbits_t;

endpackage

// File: rtl/hf_bit_accum.sv
// rtl/hf_bit_accum.sv - LSB-first bit accumulator with same-cycle byte pop and append
module hf_bit_accum #(
  parameter int ACC_W  = 16,
  parameter int DIN_W  = 4,
  parameter int FILL_W = 5,
  parameter int PN_W   = 3,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PN_W-1:0]   push_n,
  input  logic [DIN_W-1:0]  push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc,
  output logic [FILL_W-1:0] fill
);

  logic [ACC_W-1:0]  acc_shift;
  logic [FILL_W-1:0] fill_shift;
  logic [DIN_W-1:0]  din_mask;
  logic [ACC_W-1:0]  din_placed;
  logic [ACC_W-1:0]  acc_next;
  logic [FILL_W-1:0] fill_next;

  // Bits above fill are kept zero, so OR-ing the new chunk in is enough.
  always_comb begin
    acc_shift  = pop ? (acc >> OUT_W) : acc;
    fill_shift = pop ? (fill - FILL_W'(OUT_W)) : fill;
    din_mask   = ~({DIN_W{1'b1}} << push_n);
    din_placed = ACC_W'(push_data & din_mask) << fill_shift;
    acc_next   = acc_shift | din_placed;
    fill_next  = fill_shift + FILL_W'(push_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      fill <= '0;
    end else if (clear) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/hf_tans_bit_packer.sv
// rtl/hf_tans_bit_packer.sv - packs recoder chunks plus final tANS state into bytes (optional HF_PACK_BYTECNT_EN)
module hf_tans_bit_packer #(
  parameter int ACC_W   = 16,
  parameter int IN_W    = 3,
  parameter int STATE_W = 4,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               PHI,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_nbits,
  input  logic [IN_W-1:0]    in_bits,
  input  logic               in_last,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_last,
  output logic [2:0]         out_pad,
`ifdef HF_PACK_BYTECNT_EN
  output logic [CNT_W-1:0]   byte_count,
`endif
  output logic               busy
);
  import hf_tans_pkg::*;

  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int DIN_W  = (IN_W > STATE_W) ? IN_W : STATE_W;
  localparam int PN_W   = $clog2(DIN_W + 1);

  pack_state_t        state;
  logic [STATE_W-1:0] state_q;
  logic [ACC_W-1:0]   acc;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_after_pop;
  logic               accept;
  logic               pop;
  logic               clear;
  logic               append_now;
  logic [PN_W-1:0]    push_n;
  logic [DIN_W-1:0]   push_data;

  assign in_ready = (state == S_RUN) && (fill <= FILL_W'(ACC_W - IN_W));
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid = 1'b0;
    case (state)
      S_RUN, S_APPEND: out_valid = (fill >= FILL_W'(OUT_W));
      S_PAD:           out_valid = (fill != '0);
      default:         out_valid = 1'b0;
    endcase
  end

  assign out_data       = acc[OUT_W-1:0];
  assign out_last       = (state == S_PAD) && (fill <= FILL_W'(OUT_W));
  assign out_pad        = out_last ? 3'(FILL_W'(OUT_W) - fill) : 3'd0;
  assign busy           = (state != S_RUN) || (fill != '0);
  assign pop            = out_valid && out_ready;
  assign clear          = pop && out_last;
  assign fill_after_pop = pop ? (fill - FILL_W'(OUT_W)) : fill;
  assign append_now     = (state == S_APPEND) && ((int'(fill_after_pop) + STATE_W) <= ACC_W);

  // Input chunks and the trailing state share one append port; they never coincide.
  always_comb begin
    push_n    = '0;
    push_data = '0;
    if (accept) begin
      push_n    = PN_W'(in_nbits);
      push_data = DIN_W'(in_bits);
    end else if (append_now) begin
      push_n    = PN_W'(STATE_W);
      push_data = DIN_W'(state_q);
    end
  end

  hf_bit_accum #(
    .ACC_W (ACC_W),
    .DIN_W (DIN_W),
    .FILL_W(FILL_W),
    .PN_W  (PN_W),
    .OUT_W (OUT_W)
  ) u_accum (
    .clk      (PHI),
    .rst_n    (RST),
    .push_n   (push_n),
    .push_data(push_data),
    .pop      (pop),
    .clear    (clear),
    .acc      (acc),
    .fill     (fill)
  );

  always_ff @(posedge PHI or negedge RST) begin
    if (!RST) begin
      state   <= S_RUN;
      state_q <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && in_last) begin
            state_q <= in_state;
            state   <= S_APPEND;
          end
        end
        S_APPEND: if (append_now) state <= S_PAD;
        S_PAD:    if (clear) state <= S_RUN;
        default:  state <= S_RUN;
      endcase
    end
  end

`ifdef HF_PACK_BYTECNT_EN
  logic stream_done;

  // The count survives the last pop and clears on the next stream's first beat.
  always_ff @(posedge PHI or negedge RST) begin
    if (!RST) begin
      byte_count  <= '0;
      stream_done <= 1'b0;
    end else begin
      if (clear) stream_done <= 1'b1;
      else if (accept) stream_done <= 1'b0;
      if (accept && stream_done) byte_count <= '0;
      else if (pop && !(&byte_count)) byte_count <= byte_count + 1'b1;
    end
  end
`endif

  a_nbits_legal: assert property (@(posedge PHI) disable iff (!RST)
    in_valid |-> (int'(in_nbits) <= IN_W));

endmodule

// File: tb/tb_hf_tans_bit_packer.sv
// tb/tb_hf_tans_bit_packer.sv - scoreboard bench for hf_tans_bit_packer
module tb_hf_tans_bit_packer;

  logic       PHI = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_nbits = 2'd0;
  logic [2:0] in_bits = 3'd0;
  logic       in_last = 1'b0;
  logic [3:0] in_state = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic [2:0] out_pad;
  logic       busy;
`ifdef HF_PACK_BYTECNT_EN
  logic [15:0] byte_count;
`endif

  int total = 0;
  int bad = 0;
  logic [11:0] sb[$];

  always #5 PHI = ~PHI;

  hf_tans_bit_packer dut (
    .PHI       (PHI),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nbits  (in_nbits),
    .in_bits   (in_bits),
    .in_last   (in_last),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_pad   (out_pad),
`ifdef HF_PACK_BYTECNT_EN
    .byte_count(byte_count),
`endif
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // {last, pad, data}
  task automatic expect_byte(input logic [7:0] d, input logic l, input logic [2:0] p);
    sb.push_back({l, p, d});
  endtask

  always @(negedge PHI) begin
    if (RST && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", {20'd0, out_last, out_pad, out_data}, 32'hFFF);
      end else begin
        check("byte", {20'd0, out_last, out_pad, out_data}, {20'd0, sb.pop_front()});
      end
    end
  end

  task automatic send_beat(input logic [1:0] n, input logic [2:0] b, input logic last, input logic [3:0] st);
    int waitc = 0;
    in_valid = 1'b1; in_nbits = n; in_bits = b; in_last = last; in_state = st;
    while (!in_ready && waitc < 100) begin
      @(posedge PHI); #1;
      waitc++;
    end
    if (!in_ready) check("beat_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge PHI); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((busy || sb.size() != 0) && c < 300) begin
      @(posedge PHI); #1;
      c++;
    end
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_sb_left"}, sb.size(), 32'd0);
  endtask

  logic [2:0] pat[5] = '{3'b011, 3'b101, 3'b110, 3'b001, 3'b111};

  initial begin
    int k;
    int c;
    logic take;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    @(negedge PHI); RST = 1'b1;
    @(posedge PHI); #1;

    // three beats fill exactly one byte
    out_ready = 1'b1;
    expect_byte(8'hF5, 1'b0, 3'd0);
    send_beat(2'd3, 3'b101, 1'b0, 4'd0);
    send_beat(2'd3, 3'b110, 1'b0, 4'd0);
    send_beat(2'd2, 3'b011, 1'b0, 4'd0);
    wait_idle("pack");

    for (int i = 0; i < 10; i++) begin
      send_beat(2'd0, 3'b111, 1'b0, 4'd0);
      check("empty_in_ready", {31'd0, in_ready}, 32'd1);
      check("empty_out_valid", {31'd0, out_valid}, 32'd0);
      check("empty_busy", {31'd0, busy}, 32'd0);
    end

    expect_byte(8'h15, 1'b1, 3'd3);
    send_beat(2'd1, 3'b001, 1'b1, 4'b1010);
    wait_idle("eos");

    // stall the output and fill the accumulator
    out_ready = 1'b0;
    in_valid = 1'b1; in_nbits = 2'd3; in_last = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      in_bits = (k < 5) ? pat[k] : 3'b000;
      in_valid = (k < 5);
      @(negedge PHI);
      take = in_ready && in_valid;
      @(posedge PHI); #1;
      if (take) k++;
    end
    in_valid = 1'b0;
    check("bp_accepted", k, 32'd5);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_data", {24'd0, out_data}, 32'hAB);
    expect_byte(8'hAB, 1'b0, 3'd0);
    expect_byte(8'hF3, 1'b0, 3'd0);
    expect_byte(8'h06, 1'b1, 3'd4);
    out_ready = 1'b1;
    send_beat(2'd1, 3'b001, 1'b1, 4'b0110);
    wait_idle("bp");

    // asynchronous reset while the last byte is waiting
    out_ready = 1'b0;
    send_beat(2'd2, 3'b010, 1'b1, 4'b1111);
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge PHI); #1;
      c++;
    end
    check("flush_out_last", {31'd0, out_last}, 32'd1);
    check("flush_out_data", {24'd0, out_data}, 32'h3E);
    check("flush_out_pad", {29'd0, out_pad}, 32'd2);
    #2 RST = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_out_last", {31'd0, out_last}, 32'd0);
    check("arst_out_pad", {29'd0, out_pad}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge PHI); #1;
    RST = 1'b1;
    expect_byte(8'hC7, 1'b0, 3'd0);
    expect_byte(8'h03, 1'b1, 3'd3);
    out_ready = 1'b1;
    send_beat(2'd3, 3'b111, 1'b0, 4'd0);
    send_beat(2'd3, 3'b000, 1'b0, 4'd0);
    send_beat(2'd3, 3'b111, 1'b1, 4'b0001);
    wait_idle("post_rst");

`ifdef HF_PACK_BYTECNT_EN
    expect_byte(8'hFF, 1'b0, 3'd0);
    expect_byte(8'hFF, 1'b0, 3'd0);
    expect_byte(8'h5F, 1'b0, 3'd0);
    expect_byte(8'h02, 1'b1, 3'd6);
    for (int i = 0; i < 7; i++) send_beat(2'd3, 3'b111, 1'b0, 4'd0);
    send_beat(2'd1, 3'b000, 1'b1, 4'b1001);
    wait_idle("cnt");
    check("byte_count_end", {16'd0, byte_count}, 32'd4);
    send_beat(2'd0, 3'b000, 1'b0, 4'd0);
    check("byte_count_clear", {16'd0, byte_count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
